// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared definitions for the sprite pixel engine:
//   - default parameter values for the engine
//   - sprite_attr_t: one sprite's on-screen attributes (en, x, y, frame, flip, anim)
//   - sprite_image(): builds the palette-index ROM image for a given geometry
//   - ROM_IMAGE_DEF: the ROM image at the default geometry
// ROM layout: FRAMES*SPR_H words of SPR_W*BPP bits, word = frame*SPR_H + row,
// pixel c of a word at bits [c*BPP +: BPP] (column 0 at the LSBs).
package sprite_pkg;

    localparam int SPR_W_DEF    = 16;
    localparam int SPR_H_DEF    = 16;
    localparam int BPP_DEF      = 2;
    localparam int FRAMES_DEF   = 4;
    localparam int COORD_W_DEF  = 10;
    localparam int ANIM_DIV_DEF = 8;
    localparam int FRAME_W_DEF  = (FRAMES_DEF > 1) ? $clog2(FRAMES_DEF) : 1;

    // Upper bound on the generated image; larger geometries are truncated.
    localparam int ROM_MAX_BITS = 16384;
    localparam int ROM_BITS_DEF = FRAMES_DEF * SPR_H_DEF * SPR_W_DEF * BPP_DEF;

    typedef struct packed {
        logic                   en;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [FRAME_W_DEF-1:0] frame;
        logic                   flip;
        logic                   anim;
    } sprite_attr_t;

    // Sprite artwork: pixel(frame, row, col) = (col + 2*row + 3*frame + 1) mod 2^bpp.
    // Gives diagonal stripes with transparent pixels and a different phase per frame.
    function automatic logic [ROM_MAX_BITS-1:0] sprite_image(input int w, input int h,
                                                             input int bpp, input int frames);
        logic [ROM_MAX_BITS-1:0] img;
        int                      val;
        int                      base;
        img = '0;
        for (int f = 0; f < frames; f++) begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    val  = c + 2 * r + 3 * f + 1;
                    base = ((f * h + r) * w + c) * bpp;
                    for (int b = 0; b < bpp; b++) begin
                        if (base + b < ROM_MAX_BITS) begin
                            img[base + b] = val[b];
                        end else begin
                            img = img;
                        end
                    end
                end
            end
        end
        return img;
    endfunction

    localparam logic [ROM_BITS_DEF-1:0] ROM_IMAGE_DEF =
        ROM_BITS_DEF'(sprite_image(SPR_W_DEF, SPR_H_DEF, BPP_DEF, FRAMES_DEF));

endpackage

// File: rtl/sprite_if.sv
// sprite_if
// Bundles the sprite engine's handshake and bus signals.
//   vsync_pulse                      frame-start strobe
//   attr_valid/attr_ready + attr_*   attribute write handshake
//   pix_valid, pix_x, pix_y          per-pixel query from the scan path
//   out_valid, pal, hit              lookup result to the colour mapper
// master: the side that drives attributes and queries; slave: the engine.
interface sprite_if
    import sprite_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FW      = FRAME_W_DEF,
    parameter int BPP     = BPP_DEF
);
    logic               vsync_pulse;
    logic               attr_valid;
    logic               attr_ready;
    logic               attr_en;
    logic [COORD_W-1:0] attr_x;
    logic [COORD_W-1:0] attr_y;
    logic [FW-1:0]      attr_frame;
    logic               attr_flip;
    logic               attr_anim;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               out_valid;
    logic [BPP-1:0]     pal;
    logic               hit;

    modport master (
        output vsync_pulse, attr_valid, attr_en, attr_x, attr_y, attr_frame,
               attr_flip, attr_anim, pix_valid, pix_x, pix_y,
        input  attr_ready, out_valid, pal, hit
    );

    modport slave (
        input  vsync_pulse, attr_valid, attr_en, attr_x, attr_y, attr_frame,
               attr_flip, attr_anim, pix_valid, pix_x, pix_y,
        output attr_ready, out_valid, pal, hit
    );
endinterface

// File: rtl/sprite_rom.sv
// sprite_rom
// Read-only sprite memory with a one-cycle synchronous read.
//   clk   in   clock
//   addr  in   word address
//   data  out  word read at the previous clock edge
// The output register carries no reset so the array maps onto block RAM or
// LUT ROM; the engine qualifies the data with its own reset-cleared flags.
module sprite_rom #(
    parameter int                       DEPTH = 64,
    parameter int                       WIDTH = 32,
    parameter int                       AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DEPTH*WIDTH-1:0]   IMAGE = '0
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] data
);
    logic [WIDTH-1:0] rom_s [DEPTH];
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign rom_s[i] = IMAGE[i*WIDTH +: WIDTH];
    end

    // Word selection for the next read.
    always_comb begin
        data_d = rom_s[addr];
    end

    // Synchronous read register.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;
endmodule

// File: rtl/sprite_engine.sv
// sprite_engine
// One-sprite pixel engine. Holds shadow/active attribute registers with a
// vsync-synchronised commit, runs a self-timed animation frame offset, and
// answers pixel queries through a 2-stage pipeline (bounds/flip/address,
// then synchronous ROM read with output mux).
//   Clk    in   system clock
//   Reset  in   asynchronous active-high reset
//   bus    sprite_if.slave: attribute handshake, queries, results
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int SPR_W    = SPR_W_DEF,
    parameter int SPR_H    = SPR_H_DEF,
    parameter int BPP      = BPP_DEF,
    parameter int FRAMES   = FRAMES_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int ANIM_DIV = ANIM_DIV_DEF
) (
    input  logic     Clk,
    input  logic     Reset,
    sprite_if.slave  bus
);
    localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW       = $clog2(SPR_W);
    localparam int RW       = $clog2(SPR_H);
    localparam int DEPTH    = FRAMES * SPR_H;
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW       = SPR_W * BPP;
    localparam int CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DW       = COORD_W + 1;
    localparam int ROM_BITS = DEPTH * WW;
    localparam logic [ROM_BITS-1:0] ROM_IMAGE =
        ROM_BITS'(sprite_image(SPR_W, SPR_H, BPP, FRAMES));

    // Attribute and animation state
    sprite_attr_t     shadow_d, shadow_q;
    logic             shadow_full_d, shadow_full_q;
    sprite_attr_t     active_d, active_q;
    logic [CNT_W-1:0] anim_cnt_d, anim_cnt_q;
    logic [FW-1:0]    anim_off_d, anim_off_q;
    sprite_attr_t     in_attr_s;
    logic             accept_s;

    // Query pipeline
    logic [DW-1:0]    dx_s, dy_s;
    logic             inside_s;
    logic [CW-1:0]    col_s;
    logic [FW-1:0]    eff_frame_s;
    logic [AW-1:0]    addr_s;
    logic             s1_valid_d, s1_valid_q;
    logic             s1_inside_d, s1_inside_q;
    logic [CW-1:0]    s1_col_d, s1_col_q;
    logic [AW-1:0]    s1_addr_d, s1_addr_q;
    logic             s2_valid_d, s2_valid_q;
    logic             s2_inside_d, s2_inside_q;
    logic [CW-1:0]    s2_col_d, s2_col_q;
    logic [WW-1:0]    rom_data_s;
    logic [BPP-1:0]   pixel_s;
    logic [BPP-1:0]   pal_s;
    logic             hit_s;

    // Pack the incoming attribute write into the stored format.
    always_comb begin
        in_attr_s       = '0;
        in_attr_s.en    = bus.attr_en;
        in_attr_s.x     = COORD_W_DEF'(bus.attr_x);
        in_attr_s.y     = COORD_W_DEF'(bus.attr_y);
        in_attr_s.frame = FRAME_W_DEF'(bus.attr_frame);
        in_attr_s.flip  = bus.attr_flip;
        in_attr_s.anim  = bus.attr_anim;
    end

    // Attribute handshake, vsync commit and animation stepping.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        anim_cnt_d    = anim_cnt_q;
        anim_off_d    = anim_off_q;
        accept_s      = bus.attr_valid && !shadow_full_q;

        if (bus.vsync_pulse && accept_s) begin
            // A write landing on vsync bypasses the shadow entirely.
            active_d      = in_attr_s;
            shadow_full_d = 1'b0;
            anim_cnt_d    = '0;
            anim_off_d    = '0;
        end else if (bus.vsync_pulse && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            anim_cnt_d    = '0;
            anim_off_d    = '0;
        end else begin
            if (accept_s) begin
                shadow_d      = in_attr_s;
                shadow_full_d = 1'b1;
            end else begin
                shadow_d      = shadow_q;
            end

            if (!active_q.anim) begin
                anim_cnt_d = '0;
                anim_off_d = '0;
            end else if (bus.vsync_pulse) begin
                if (anim_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                    anim_cnt_d = '0;
                    anim_off_d = anim_off_q + FW'(1);
                end else begin
                    anim_cnt_d = anim_cnt_q + CNT_W'(1);
                end
            end else begin
                anim_cnt_d = anim_cnt_q;
            end
        end
    end

    // Stage 1 combinational: bounds test, flipped column and ROM address.
    always_comb begin
        dx_s = {1'b0, COORD_W'(bus.pix_x)} - {1'b0, COORD_W'(active_q.x)};
        dy_s = {1'b0, COORD_W'(bus.pix_y)} - {1'b0, COORD_W'(active_q.y)};
        // Bit COORD_W is the borrow: set when the query lies left of/above the sprite.
        inside_s = active_q.en && !dx_s[COORD_W] && !dy_s[COORD_W]
                   && (dx_s < DW'(SPR_W)) && (dy_s < DW'(SPR_H));
        // SPR_W is a power of 2, so SPR_W-1-dx is the bitwise complement.
        if (active_q.flip) begin
            col_s = ~dx_s[CW-1:0];
        end else begin
            col_s = dx_s[CW-1:0];
        end
        // FRAMES is a power of 2, so the FW-bit add wraps modulo FRAMES.
        if (FRAMES == 1) begin
            eff_frame_s = '0;
        end else begin
            eff_frame_s = FW'(active_q.frame) + anim_off_q;
        end
        addr_s = AW'({eff_frame_s, dy_s[RW-1:0]});
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d  = bus.pix_valid;
        s1_inside_d = inside_s;
        s1_col_d    = col_s;
        s1_addr_d   = addr_s;
        s2_valid_d  = s1_valid_q;
        s2_inside_d = s1_inside_q;
        s2_col_d    = s1_col_q;
    end

    // State registers for attributes, animation and pipeline flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            anim_cnt_q    <= '0;
            anim_off_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_inside_q   <= 1'b0;
            s1_col_q      <= '0;
            s1_addr_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_inside_q   <= 1'b0;
            s2_col_q      <= '0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_off_q    <= anim_off_d;
            s1_valid_q    <= s1_valid_d;
            s1_inside_q   <= s1_inside_d;
            s1_col_q      <= s1_col_d;
            s1_addr_q     <= s1_addr_d;
            s2_valid_q    <= s2_valid_d;
            s2_inside_q   <= s2_inside_d;
            s2_col_q      <= s2_col_d;
        end
    end

    sprite_rom #(
        .DEPTH (DEPTH),
        .WIDTH (WW),
        .AW    (AW),
        .IMAGE (ROM_IMAGE)
    ) u_rom (
        .clk  (Clk),
        .addr (s1_addr_q),
        .data (rom_data_s)
    );

    // Stage 2: pick the column out of the ROM word and gate by the stage flags.
    always_comb begin
        pixel_s = '0;
        for (int c = 0; c < SPR_W; c++) begin
            if (s2_col_q == CW'(c)) begin
                pixel_s = rom_data_s[c*BPP +: BPP];
            end else begin
                pixel_s = pixel_s;
            end
        end
        if (s2_valid_q && s2_inside_q) begin
            pal_s = pixel_s;
        end else begin
            pal_s = '0;
        end
        hit_s = (pal_s != '0);
    end

    assign bus.attr_ready = !shadow_full_q;
    assign bus.out_valid  = s2_valid_q;
    assign bus.pal        = pal_s;
    assign bus.hit        = hit_s;
endmodule
